uart_frame_tx: RTL and testbench

Transmit-side frame packer for the UART command link. The receive path accepts 8-byte frames headed 0x07 and decodes them into pulse_width/pulse_gap settings. This block builds the matching 8-byte reply frame: header, status, echoed pulse settings, fire count and checksum. It feeds the bytes one at a time into the existing byte-level uart_tx through its pi_data/pi_flag pair, pacing them so no byte is overwritten mid-transmission. It sits in top_functionGenerate between the command/pulse logic and uart_tx_inst.

---
 rtl/uart_frame_tx.sv | 135 +++++++++++++
 tb/tb_uart_frame_tx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: builds the 8-byte reply frame (header, status, pulse
// settings, fire count, checksum) and hands it byte by byte to the
// byte-level uart_tx via pi_data/pi_flag. Bytes are spaced BYTE_GAP cycles
// apart so uart_tx is never reloaded while it is still shifting a byte out.
module uart_frame_tx #(
    parameter logic [13:0] UART_BPS   = 14'd9600,
    parameter logic [25:0] CLK_FREQ   = 26'd50_000_000,
    parameter logic [7:0]  RSP_HEADER = 8'h87
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        frame_req,
    input  logic [7:0]  status,
    input  logic [6:0]  pulse_width1,
    input  logic [6:0]  pulse_width2,
    input  logic [6:0]  pulse_gap,
    input  logic [15:0] pulse_cnt,
    output logic [7:0]  pi_data,
    output logic        pi_flag,
    output logic        busy,
    output logic        frame_done,
    output logic        req_drop
);

    // One UART bit period, and the byte spacing: 10 bits plus a spare bit.
    localparam int BIT_CYC  = int'(CLK_FREQ / 26'(UART_BPS));
    localparam int BYTE_GAP = 11 * BIT_CYC;
    // SEND takes one cycle, WAIT covers the remaining BYTE_GAP-1 cycles.
    localparam logic [19:0] GAP_LAST = 20'(BYTE_GAP - 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [19:0] gap_cnt;
    logic [2:0]  idx;
    logic [7:0]  csum;
    logic [7:0]  last_byte;
    logic [7:0]  cur_byte;
    logic        accept;
    logic        gap_end;
    logic        req_drop_q;

    // Snapshot of the reply fields taken when the request is accepted.
    logic [7:0]  status_q;
    logic [6:0]  width1_q;
    logic [6:0]  width2_q;
    logic [6:0]  gap_q;
    logic [15:0] cnt_q;

    // DONE already counts as idle for a new request, so a request on the
    // frame_done cycle starts the next frame without a drop.
    assign accept  = frame_req && (state == IDLE || state == DONE);
    assign gap_end = (gap_cnt == GAP_LAST);

    // Select the byte for the current index; the last byte is the checksum.
    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0: cur_byte = RSP_HEADER;
            3'd1: cur_byte = status_q;
            3'd2: cur_byte = {1'b0, width1_q};
            3'd3: cur_byte = {1'b0, width2_q};
            3'd4: cur_byte = {1'b0, gap_q};
            3'd5: cur_byte = cnt_q[15:8];
            3'd6: cur_byte = cnt_q[7:0];
            3'd7: cur_byte = csum;
            default: cur_byte = 8'h00;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic: one SEND cycle per byte, then pace out the gap.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (frame_req) state_nxt = SEND;
            SEND: state_nxt = WAIT;
            WAIT: if (gap_end) state_nxt = (idx == 3'd7) ? DONE : SEND;
            DONE: state_nxt = frame_req ? SEND : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Field latch, byte index, checksum accumulation and gap counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            status_q  <= 8'h00;
            width1_q  <= 7'h00;
            width2_q  <= 7'h00;
            gap_q     <= 7'h00;
            cnt_q     <= 16'h0000;
            idx       <= 3'd0;
            csum      <= 8'h00;
            gap_cnt   <= 20'd0;
            last_byte <= 8'h00;
        end else begin
            if (accept) begin
                status_q <= status;
                width1_q <= pulse_width1;
                width2_q <= pulse_width2;
                gap_q    <= pulse_gap;
                cnt_q    <= pulse_cnt;
                idx      <= 3'd0;
                csum     <= 8'h00;
            end
            if (state == SEND) begin
                last_byte <= cur_byte;
                gap_cnt   <= 20'd0;
                if (idx != 3'd7) csum <= csum + cur_byte;
            end
            if (state == WAIT) begin
                gap_cnt <= gap_cnt + 20'd1;
                if (gap_end && idx != 3'd7) idx <= idx + 3'd1;
            end
        end
    end

    // Flag a request that arrives while a frame is still being sent.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) req_drop_q <= 1'b0;
        else            req_drop_q <= frame_req && (state == SEND || state == WAIT);
    end

    assign pi_flag    = (state == SEND);
    assign pi_data    = (state == SEND) ? cur_byte : last_byte;
    assign busy       = (state == SEND || state == WAIT);
    assign frame_done = (state == DONE);
    assign req_drop   = req_drop_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx at CLK_FREQ=100, UART_BPS=10 (BYTE_GAP=110).
// A negedge monitor logs every pi_flag/frame_done/req_drop with its cycle
// number; each scenario task compares the log against a frame computed
// directly from the field values.
module tb_uart_frame_tx;

    localparam int G = 110;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_req = 1'b0;
    logic [7:0]  status = 8'h00;
    logic [6:0]  pulse_width1 = 7'h00;
    logic [6:0]  pulse_width2 = 7'h00;
    logic [6:0]  pulse_gap = 7'h00;
    logic [15:0] pulse_cnt = 16'h0000;
    logic [7:0]  pi_data;
    logic        pi_flag, busy, frame_done, req_drop;

    uart_frame_tx #(.UART_BPS(14'd10), .CLK_FREQ(26'd100), .RSP_HEADER(8'h87)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_req(frame_req),
        .status(status), .pulse_width1(pulse_width1), .pulse_width2(pulse_width2),
        .pulse_gap(pulse_gap), .pulse_cnt(pulse_cnt), .pi_data(pi_data),
        .pi_flag(pi_flag), .busy(busy), .frame_done(frame_done), .req_drop(req_drop)
    );

    always #5 sys_clk = ~sys_clk;

    int edge_no = 0;
    always @(posedge sys_clk) edge_no <= edge_no + 1;

    int n_chk = 0;
    int n_fail = 0;

    int         flag_cyc[$];
    logic [7:0] flag_dat[$];
    int         done_cyc[$];
    int         drop_cyc[$];
    logic [7:0] exp_b[8];

    // Cycle after edge n is cycle n+1.
    always @(negedge sys_clk) begin
        if (pi_flag) begin
            flag_cyc.push_back(edge_no + 1);
            flag_dat.push_back(pi_data);
        end
        if (frame_done) done_cyc.push_back(edge_no + 1);
        if (req_drop)   drop_cyc.push_back(edge_no + 1);
    end

    task automatic clear_mon();
        flag_cyc.delete(); flag_dat.delete(); done_cyc.delete(); drop_cyc.delete();
    endtask

    // Reference frame: fields in order, then their 8-bit sum.
    task automatic set_fields(input logic [7:0] s, input logic [6:0] w1, input logic [6:0] w2,
                              input logic [6:0] g, input logic [15:0] c);
        int sum;
        status = s; pulse_width1 = w1; pulse_width2 = w2; pulse_gap = g; pulse_cnt = c;
        exp_b[0] = 8'h87; exp_b[1] = s; exp_b[2] = {1'b0, w1}; exp_b[3] = {1'b0, w2};
        exp_b[4] = {1'b0, g}; exp_b[5] = c[15:8]; exp_b[6] = c[7:0];
        sum = 0;
        for (int i = 0; i < 7; i++) sum += int'(exp_b[i]);
        exp_b[7] = 8'(sum % 256);
    endtask

    task automatic wait_until(input int t);
        while (edge_no < t) @(negedge sys_clk);
    endtask

    // Pulse frame_req for one edge; k is the edge that samples it.
    task automatic send_req(output int k);
        @(negedge sys_clk);
        frame_req = 1'b1;
        k = edge_no + 1;
        @(negedge sys_clk);
        frame_req = 1'b0;
    endtask

    task automatic randomize_fields();
        set_fields(8'($urandom), 7'($urandom), 7'($urandom), 7'($urandom), 16'($urandom));
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_chk++;
        if ({pi_data, pi_flag, busy, frame_done, req_drop} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got data=%h flag=%b busy=%b done=%b drop=%b, need all 0",
                     pi_data, pi_flag, busy, frame_done, req_drop);
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            n_chk++;
            if (pi_flag !== 1'b0 || busy !== 1'b0 || pi_data !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_quiet cycle %0d: flag=%b busy=%b data=%h, need 0/0/00",
                         i, pi_flag, busy, pi_data);
            end
        end
    endtask

    task automatic test_frame();
        int k;
        int sum;
        clear_mon();
        set_fields(8'h01, 7'h05, 7'h0A, 7'h14, 16'h0102);
        send_req(k);
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise: busy=%b need 1", busy); end
        wait_until(k + 8*G + 5);
        n_chk++;
        if (flag_cyc.size() != 8) begin
            n_fail++; $display("FAIL frame_count: %0d flags, need 8", flag_cyc.size());
        end
        for (int i = 0; i < 8 && i < flag_cyc.size(); i++) begin
            n_chk++;
            if (flag_cyc[i] != k + 1 + i*G || flag_dat[i] !== exp_b[i]) begin
                n_fail++;
                $display("FAIL frame_byte%0d: cycle %0d data %h, need cycle %0d data %h",
                         i, flag_cyc[i] - k, flag_dat[i], 1 + i*G, exp_b[i]);
            end
        end
        sum = 0;
        for (int i = 0; i < 7 && i < flag_dat.size(); i++) sum += int'(flag_dat[i]);
        n_chk++;
        if (flag_dat.size() != 8 || flag_dat[7] !== 8'(sum % 256)) begin
            n_fail++; $display("FAIL frame_checksum: byte count %0d, need sum %h", flag_dat.size(), 8'(sum % 256));
        end
        n_chk++;
        if (done_cyc.size() != 1 || done_cyc[0] != k + 1 + 8*G) begin
            n_fail++; $display("FAIL frame_done: %0d pulses, first at %0d, need one at %0d",
                               done_cyc.size(), done_cyc.size() ? done_cyc[0] - k : -1, 1 + 8*G);
        end
        n_chk++;
        if (busy !== 1'b0 || pi_data !== exp_b[7]) begin
            n_fail++; $display("FAIL frame_after: busy=%b data=%h, need 0 and %h", busy, pi_data, exp_b[7]);
        end
    endtask

    task automatic test_input_hold();
        int k;
        clear_mon();
        set_fields(8'h01, 7'h05, 7'h0A, 7'h14, 16'h0102);
        send_req(k);
        wait_until(k + 4);
        status = 8'hFF; pulse_width1 = 7'h7F; pulse_width2 = 7'h7F; pulse_gap = 7'h7F; pulse_cnt = 16'hFFFF;
        wait_until(k + 8*G + 5);
        n_chk++;
        if (flag_dat.size() != 8) begin
            n_fail++; $display("FAIL hold_count: %0d bytes, need 8", flag_dat.size());
        end
        for (int i = 0; i < 8 && i < flag_dat.size(); i++) begin
            n_chk++;
            if (flag_dat[i] !== exp_b[i]) begin
                n_fail++; $display("FAIL hold_byte%0d: got %h need %h", i, flag_dat[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_drop();
        int k;
        clear_mon();
        randomize_fields();
        send_req(k);
        wait_until(k + 299);
        frame_req = 1'b1;
        status = ~status; pulse_cnt = ~pulse_cnt;
        @(negedge sys_clk);
        frame_req = 1'b0;
        wait_until(k + 8*G + 150);
        n_chk++;
        if (drop_cyc.size() != 1 || drop_cyc[0] != k + 301) begin
            n_fail++; $display("FAIL drop_pulse: %0d pulses, first at %0d, need one at 301",
                               drop_cyc.size(), drop_cyc.size() ? drop_cyc[0] - k : -1);
        end
        n_chk++;
        if (flag_cyc.size() != 8) begin
            n_fail++; $display("FAIL drop_flags: %0d flags, need 8", flag_cyc.size());
        end
        for (int i = 0; i < 8 && i < flag_dat.size(); i++) begin
            n_chk++;
            if (flag_dat[i] !== exp_b[i]) begin
                n_fail++; $display("FAIL drop_byte%0d: got %h need %h", i, flag_dat[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        int k2;
        clear_mon();
        randomize_fields();
        send_req(k);
        wait_until(k + 249);
        sys_rst_n = 1'b0;
        #1;
        n_chk++;
        if ({pi_data, pi_flag, busy, frame_done, req_drop} !== 12'h000) begin
            n_fail++; $display("FAIL midreset_out: data=%h flag=%b busy=%b, need 0", pi_data, pi_flag, busy);
        end
        n_chk++;
        if (flag_cyc.size() != 3) begin
            n_fail++; $display("FAIL midreset_partial: %0d flags before reset, need 3", flag_cyc.size());
        end
        wait_until(k + 259);
        sys_rst_n = 1'b1;
        clear_mon();
        randomize_fields();
        wait_until(k + 299);
        frame_req = 1'b1;
        k2 = k + 300;
        @(negedge sys_clk);
        frame_req = 1'b0;
        wait_until(k2 + 8*G + 5);
        n_chk++;
        if (flag_cyc.size() != 8 || done_cyc.size() != 1) begin
            n_fail++; $display("FAIL midreset_frame: %0d flags %0d dones, need 8 and 1",
                               flag_cyc.size(), done_cyc.size());
        end
        for (int i = 0; i < 8 && i < flag_cyc.size(); i++) begin
            n_chk++;
            if (flag_cyc[i] != k2 + 1 + i*G || flag_dat[i] !== exp_b[i]) begin
                n_fail++; $display("FAIL midreset_byte%0d: cycle %0d data %h, need %0d %h",
                                   i, flag_cyc[i] - k2, flag_dat[i], 1 + i*G, exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int k2;
        clear_mon();
        randomize_fields();
        send_req(k);
        wait_until(k + 8*G);
        n_chk++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_done: done=%b busy=%b, need 1/0", frame_done, busy);
        end
        n_chk++;
        if (flag_dat.size() != 8 || flag_dat[7] !== exp_b[7]) begin
            n_fail++; $display("FAIL b2b_first: %0d bytes, need 8 ending %h", flag_dat.size(), exp_b[7]);
        end
        clear_mon();
        randomize_fields();
        frame_req = 1'b1;
        k2 = edge_no + 1;
        @(negedge sys_clk);
        frame_req = 1'b0;
        wait_until(k2 + 8*G + 5);
        n_chk++;
        if (drop_cyc.size() != 0 || flag_cyc.size() != 8 || done_cyc[done_cyc.size()-1] != k2 + 1 + 8*G) begin
            n_fail++; $display("FAIL b2b_second: drops %0d flags %0d, need 0 and 8 with done at %0d",
                               drop_cyc.size(), flag_cyc.size(), 1 + 8*G);
        end
        for (int i = 0; i < 8 && i < flag_cyc.size(); i++) begin
            n_chk++;
            if (flag_cyc[i] != k2 + 1 + i*G || flag_dat[i] !== exp_b[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: cycle %0d data %h, need %0d %h",
                                   i, flag_cyc[i] - k2, flag_dat[i], 1 + i*G, exp_b[i]);
            end
        end
    endtask

    task automatic test_random();
        int k;
        for (int f = 0; f < 6; f++) begin
            clear_mon();
            randomize_fields();
            repeat ($urandom_range(0, 20)) @(negedge sys_clk);
            send_req(k);
            wait_until(k + 8*G + 3);
            n_chk++;
            if (flag_cyc.size() != 8 || done_cyc.size() != 1) begin
                n_fail++; $display("FAIL rand%0d_count: %0d flags %0d dones", f, flag_cyc.size(), done_cyc.size());
            end
            for (int i = 0; i < 8 && i < flag_cyc.size(); i++) begin
                n_chk++;
                if (flag_cyc[i] != k + 1 + i*G || flag_dat[i] !== exp_b[i]) begin
                    n_fail++; $display("FAIL rand%0d_byte%0d: cycle %0d data %h, need %0d %h",
                                       f, i, flag_cyc[i] - k, flag_dat[i], 1 + i*G, exp_b[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_input_hold();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
